// File: rtl/iiitb_aclock_disp.sv
// iiitb_aclock_disp: 6-digit multiplexed 7-segment display stage for the alarm clock.
// Snapshots HH:MM:SS + Alarm once per scan frame, scans one digit per SCAN_DIV
// clocks, blinks the whole display while the alarm is active.
// Ports:
//   clk, reset          - clock, async active-high reset
//   H_out1..S_out0      - BCD time digits (H_out1 is 2 bits)
//   Alarm               - alarm active flag
//   an[5:0]             - digit enables, bit0 = seconds units .. bit5 = hours tens
//   seg[6:0]            - segments {g,f,e,d,c,b,a}
//   dp                  - decimal point (separator after hours and minutes)
//   frame_start         - 1-cycle pulse when a new snapshot is taken
module iiitb_aclock_disp #(
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_DIV  = 8,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit LZ_BLANK   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] H_out1,
    input  logic [3:0] H_out0,
    input  logic [3:0] M_out1,
    input  logic [3:0] M_out0,
    input  logic [3:0] S_out1,
    input  logic [3:0] S_out0,
    input  logic       Alarm,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

    // Physical "all off" patterns; XOR with these applies output polarity.
    localparam logic [5:0] AN_OFF  = {6{ACTIVE_LOW}};
    localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW}};
    localparam logic       DP_OFF  = ACTIVE_LOW;

    logic [PW-1:0]   r_presc;
    logic [2:0]      r_idx;
    logic [5:0][3:0] r_snap;
    logic [BW-1:0]   r_blink_cnt;
    logic            r_phase;
    logic            r_load_pending;

    logic            w_tc;
    logic            w_load;
    logic [3:0]      w_digit;
    logic            w_lz;
    logic [5:0]      w_an;
    logic [6:0]      w_seg;
    logic            w_dp;

    function automatic logic [6:0] f_dec(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    assign w_tc   = (r_presc == P_LAST);
    assign w_load = r_load_pending | (w_tc & (r_idx == 3'd5));

    always_comb begin
        w_digit = 4'd0;
        case (r_idx)
            3'd0:    w_digit = r_snap[0];
            3'd1:    w_digit = r_snap[1];
            3'd2:    w_digit = r_snap[2];
            3'd3:    w_digit = r_snap[3];
            3'd4:    w_digit = r_snap[4];
            3'd5:    w_digit = r_snap[5];
            default: w_digit = 4'd0;
        endcase
    end

    // Logical (active-high) view of the digit being scanned.
    always_comb begin
        w_lz  = LZ_BLANK && (r_idx == 3'd5) && (r_snap[5] == 4'd0);
        w_an  = 6'd1 << r_idx;
        w_seg = w_lz ? 7'd0 : f_dec(w_digit);
        w_dp  = !w_lz && ((r_idx == 3'd2) || (r_idx == 3'd4));
        if (r_phase) begin
            w_an  = 6'd0;
            w_seg = 7'd0;
            w_dp  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc        <= '0;
            r_idx          <= 3'd0;
            r_snap         <= '0;
            r_blink_cnt    <= '0;
            r_phase        <= 1'b0;
            r_load_pending <= 1'b1;
            frame_start    <= 1'b0;
            an             <= AN_OFF;
            seg            <= SEG_OFF;
            dp             <= DP_OFF;
        end else begin
            frame_start <= w_load;
            if (r_load_pending) begin
                // First edge after reset only primes the snapshot; the
                // scan starts on the next edge so idx0 gets a full slot.
                r_load_pending <= 1'b0;
                an             <= AN_OFF;
                seg            <= SEG_OFF;
                dp             <= DP_OFF;
            end else begin
                r_presc <= w_tc ? '0 : r_presc + PW'(1);
                if (w_tc)
                    r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
                an  <= w_an ^ AN_OFF;
                seg <= w_seg ^ SEG_OFF;
                dp  <= w_dp ^ DP_OFF;
            end
            if (w_load) begin
                r_snap <= {{2'b00, H_out1}, H_out0, M_out1,
                           M_out0, S_out1, S_out0};
                // Alarm is taken with the snapshot, so blink state only
                // moves on frame boundaries.
                if (!Alarm) begin
                    r_blink_cnt <= '0;
                    r_phase     <= 1'b0;
                end else if (r_blink_cnt == B_LAST) begin
                    r_blink_cnt <= '0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_iiitb_aclock_disp.sv
// tb_iiitb_aclock_disp: directed bench for the multiplexed display stage.
// Expected scan frames are queued when inputs are set and popped per cycle.
module tb_iiitb_aclock_disp;

    localparam int SD = 4;
    localparam int BD = 2;
    localparam bit AL = 1'b1;
    localparam int FRAME = 6 * SD;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] H_out1;
    logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;
    logic       Alarm;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    always #5 clk = ~clk;

    iiitb_aclock_disp #(
        .SCAN_DIV(SD), .BLINK_DIV(BD), .ACTIVE_LOW(AL), .LZ_BLANK(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .H_out1(H_out1), .H_out0(H_out0),
        .M_out1(M_out1), .M_out0(M_out0),
        .S_out1(S_out1), .S_out0(S_out0),
        .Alarm(Alarm),
        .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
    );

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } vec_t;

    vec_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    function automatic vec_t idle_vec();
        vec_t e;
        e.an  = AL ? 6'h3f : 6'h00;
        e.seg = AL ? 7'h7f : 7'h00;
        e.dp  = AL;
        e.fs  = 1'b0;
        return e;
    endfunction

    // d = {H1,H0,M1,M0,S1,S0} nibbles
    task automatic push_frame(input logic [23:0] d, input bit blank);
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < SD; c++) begin
                vec_t       e;
                logic [3:0] v;
                bit         lz;
                v     = d[i*4 +: 4];
                lz    = (i == 5) && (v == 4'd0);
                e.an  = blank ? 6'd0 : 6'(1 << i);
                e.seg = (blank || lz) ? 7'd0 : seg_of(v);
                e.dp  = !blank && !lz && (i == 2 || i == 4);
                if (AL) begin
                    e.an  = ~e.an;
                    e.seg = ~e.seg;
                    e.dp  = ~e.dp;
                end
                e.fs = (i == 5) && (c == SD - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic cmp(input string tag, input vec_t exp);
        vec_t got;
        got = {an, seg, dp, frame_start};
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got an=%b seg=%b dp=%b fs=%b exp an=%b seg=%b dp=%b fs=%b",
                   tag, got.an, got.seg, got.dp, got.fs,
                   exp.an, exp.seg, exp.dp, exp.fs);
        end
    endtask

    task automatic check_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            vec_t exp;
            @(negedge clk);
            exp = (q.size() > 0) ? q.pop_front() : idle_vec();
            cmp($sformatf("%s[%0d]", tag, i), exp);
        end
    endtask

    task automatic wait_frame(input string tag);
        int k = 0;
        while (frame_start !== 1'b1 && k < 64) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        assert (frame_start === 1'b1) else begin
            n_err++;
            $error("FAIL %s frame_start got %b exp 1", tag, frame_start);
        end
    endtask

    task automatic run_frame(input string tag, input logic [23:0] d,
                             input bit blank);
        push_frame(d, blank);
        wait_frame(tag);
        check_cycles(tag, FRAME);
    endtask

    initial begin
        {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0} = 22'h123456;
        Alarm = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        cmp("reset_idle", idle_vec());

        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        assert (frame_start === 1'b1) else begin
            n_err++;
            $error("FAIL fs_cycle1 frame_start got %b exp 1", frame_start);
        end
        run_frame("frame1", 24'h123456, 1'b0);

        push_frame(24'h123456, 1'b0);
        wait_frame("midchg");
        check_cycles("midchg_a", 10);
        S_out0 = 4'd7;
        check_cycles("midchg_b", FRAME - 10);
        run_frame("new_s0", 24'h123457, 1'b0);

        {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0} = 22'h095959;
        run_frame("pre_lz", 24'h123457, 1'b0);
        run_frame("lz", 24'h095959, 1'b0);

        {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0} = 22'h23595B;
        run_frame("pre_dash", 24'h095959, 1'b0);
        run_frame("dash", 24'h23595B, 1'b0);

        Alarm = 1'b1;
        run_frame("al_x", 24'h23595B, 1'b0);
        run_frame("al_f1", 24'h23595B, 1'b0);
        run_frame("al_f2", 24'h23595B, 1'b1);
        run_frame("al_f3", 24'h23595B, 1'b1);
        run_frame("al_f4", 24'h23595B, 1'b0);
        run_frame("al_f5", 24'h23595B, 1'b0);
        Alarm = 1'b0;
        run_frame("al_f6", 24'h23595B, 1'b1);
        run_frame("al_off", 24'h23595B, 1'b0);
        run_frame("al_off2", 24'h23595B, 1'b0);

        push_frame(24'h23595B, 1'b0);
        wait_frame("pre_rst");
        check_cycles("pre_rst", 9);
        q.delete();
        @(posedge clk);
        #2 reset = 1'b1;
        #1 cmp("rst_async", idle_vec());
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp($sformatf("rst_hold[%0d]", i), idle_vec());
        end
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        assert (frame_start === 1'b1) else begin
            n_err++;
            $error("FAIL rst_fs frame_start got %b exp 1", frame_start);
        end
        run_frame("post_rst", 24'h23595B, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/iiitb_aclock_disp.md
Name: iiitb_aclock_disp

Overview:
Downstream display stage for the alarm clock core. It consumes the six BCD time digits (HH:MM:SS) and the Alarm flag, and drives a 6-digit time-multiplexed 7-segment display. The six inputs are snapshotted once per scan frame so a displayed frame never mixes old and new digits. The whole display blinks while Alarm is asserted.

Parameters:
SCAN_DIV, 1000, clk cycles each digit stays enabled (>=2)
BLINK_DIV, 8, scan frames per blink half-period (>=1)
ACTIVE_LOW, 1, 1 = an/seg/dp driven active-low (common anode); 0 = active-high
LZ_BLANK, 1, 1 = blank the hours-tens digit when it is 0

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
H_out1  in  2  hours tens (0-2)
H_out0  in  4  hours units BCD
M_out1  in  4  minutes tens BCD
M_out0  in  4  minutes units BCD
S_out1  in  4  seconds tens BCD
S_out0  in  4  seconds units BCD
Alarm  in  1  alarm active from the clock core
an  out  6  digit enables, one-hot when lit; bit0 = S_out0 ... bit5 = H_out1
seg  out  7  segments {g,f,e,d,c,b,a}
dp  out  1  decimal point, used as separator
frame_start  out  1  1-cycle pulse when a new snapshot is taken

Behaviour:
- One clock domain. Reset is asynchronous and active-high. Every register clears immediately on reset.
- All description below is in logical (active-high) terms. When ACTIVE_LOW=1, the an, seg and dp outputs are bit-inverted at the output register.
- Reset values: an, seg and dp are all inactive (logical 0); frame_start=0; prescaler=0; digit_idx=0; snapshot=0; blink counter=0; blink phase=0; load_pending=1.
- Prescaler: counts 0..SCAN_DIV-1, then wraps to 0. The terminal count (tc) is prescaler==SCAN_DIV-1.
- digit_idx: advances on tc, 0->1->...->5->0.
- Snapshot load: occurs on the edge where tc && digit_idx==5, or on the first edge with load_pending=1 (load_pending then clears).
  - The snapshot latches all six digits, with H_out1 zero-extended to 4 bits, plus Alarm.
  - frame_start is registered high for exactly that one cycle.
- Digit mapping: idx0=S_out0, 1=S_out1, 2=M_out0, 3=M_out1, 4=H_out0, 5=H_out1.
- Decode (gfedcba): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111. Values 10-15 decode to 1000000 (dash).
- dp: lit when the displayed digit is idx2 or idx4 (HH.MM.SS separators). It follows the same blanking rules as seg.
- Output register: an, seg and dp are registered from the current digit_idx and snapshot, so they lag digit_idx by exactly 1 cycle. an=1<<digit_idx.
- Leading-zero blank: when LZ_BLANK=1, idx5 and snapshot H1==0, seg=0 and dp=0. an stays asserted so the scan timing is unchanged.
- Blink: the blink counter advances on each snapshot load while the snapshot Alarm=1. When it reaches BLINK_DIV-1, it wraps to 0 and the blink phase toggles.
  - When the snapshot Alarm=0, the counter and phase are forced to 0 on the next snapshot load.
  - While phase=1, an=0, seg=0 and dp=0 for the whole frame.
  - Alarm and phase changes therefore only take effect on frame boundaries, never mid-frame.
- Input changes mid-frame: ignored until the next snapshot load.
- Reset mid-frame: outputs go inactive immediately. After release, a fresh snapshot is taken on the first edge (load_pending) and the scan restarts at idx0.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then release, SCAN_DIV=4, inputs 12:34:56, Alarm=0 -> frame_start at cycle 1. an walks 000001..100000, 4 cycles each. seg per digit: 6=1111101, 5=1101101, 4=1100110 with dp=1, 3=1001111, 2=1011011 with dp=1, 1=0000110 (logical). Phys outputs are inverted when ACTIVE_LOW=1.
- Change S_out0 from 6 to 7 at mid-frame -> current frame still shows 6 on idx0. The next frame, after frame_start, shows 0000111.
- H_out1=0, LZ_BLANK=1, input 09:59:59 -> during idx5 an=100000 with seg=0000000 and dp=0. All other digits decode normally.
- Alarm=1, BLINK_DIV=2 -> 2 frames lit, 2 frames fully blank (an=0), repeating. Drop Alarm -> display solid from the next frame boundary, phase=0.
- Drive S_out0=4'hB -> idx0 shows dash 1000000.
- Assert reset for 3 cycles mid-scan -> an, seg and dp are inactive within the same cycle. After release, idx0 is displayed first and frame_start pulses once.
